mem_wb_skid: RTL
================

MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width.
REQ-002 SHALL have parameter RD_W, default 5, destination register index width.
REQ-003 SHALL have parameter FWD_RESULT, default 1: 1 = drive o_wb_result; 0 = tie o_wb_result to 0.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port i_resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_flush, input, 1, discard all held entries.
REQ-007 SHALL have port i_mem_valid, input, 1, MEM stage offers an entry.
REQ-008 SHALL have port o_mem_ready, output, 1, block can accept an entry this cycle.
REQ-009 SHALL have port i_mem_mem2reg, input, 1, writeback selects load data.
REQ-010 SHALL have port i_mem_wreg, input, 1, register-file write enable.
REQ-011 SHALL have port i_mem_rd, input, RD_W, destination index.
REQ-012 SHALL have port i_mem_data, input, XLEN, ALU/forwarded result.
REQ-013 SHALL have port i_rd_dmem, input, XLEN, data-memory read data.
REQ-014 SHALL have port o_wb_valid, output, 1, WB entry present.
REQ-015 SHALL have port i_wb_ready, input, 1, WB stage consumes the entry.
REQ-016 SHALL have ports o_wb_mem2reg (1), o_wb_wreg (1), o_wb_rd (RD_W), o_wb_data (XLEN), o_wb_dmem (XLEN), outputs, registered copies of the head entry.
REQ-017 SHALL have port o_wb_result, output, XLEN, o_wb_mem2reg ? o_wb_dmem : o_wb_data (combinational from registers).

Function
REQ-018 SHALL implement a 2-entry skid buffer: head register (drives outputs) plus skid register.
REQ-019 SHALL have states EMPTY (no entries), ONE (head only), TWO (head and skid).
REQ-020 SHALL accept on an edge where i_mem_valid && o_mem_ready; SHALL drain on an edge where o_wb_valid && i_wb_ready.
REQ-021 SHALL transition: EMPTY+accept -> ONE; ONE+accept+drain -> ONE; ONE+accept only -> TWO; ONE+drain only -> EMPTY; TWO+drain -> ONE (skid moves to head); otherwise hold state.
REQ-022 SHALL drive o_mem_ready from a register, high in EMPTY and ONE, low in TWO; no combinational path from i_wb_ready to o_mem_ready.
REQ-023 SHALL give 1-cycle latency from accept to o_wb_valid when EMPTY, and sustain 1 entry/cycle while i_wb_ready stays high.
REQ-024 SHALL hold all o_wb_* outputs stable while o_wb_valid && !i_wb_ready.
REQ-025 SHALL preserve entry order; no entry is lost or duplicated.
REQ-026 SHALL sanitise on capture: when i_mem_wreg=0 or i_mem_rd=0, store wreg=0 and rd=0; data fields are stored unchanged.
REQ-027 SHALL, when i_flush=1 at an edge, go to EMPTY, set o_wb_valid=0 and o_mem_ready=1, and ignore any simultaneous accept or drain (flush wins).
REQ-028 SHALL force o_wb_wreg=0 whenever o_wb_valid=0.

Reset
REQ-029 SHALL, on i_resetn low, asynchronously enter EMPTY with o_wb_valid=0, o_mem_ready=1 and all o_wb_* fields and skid contents 0; a mid-transfer reset discards all entries.
REQ-030 SHALL resume operation on the first rising edge after i_resetn deasserts.

Structure
REQ-031 SHALL take the state encoding (EMPTY/ONE/TWO) and the entry-record field layout from the shared pipeline package.
REQ-032 SHALL be a single module; skid and head registers are not separate sub-modules.

Verification
REQ-033 Stream 4 entries with i_wb_ready=1 -> one o_wb_valid per cycle, 1-cycle latency, o_mem_ready stays 1.
REQ-034 Accept A, B with i_wb_ready=0 -> TWO, o_mem_ready=0, head=A stable; raise i_wb_ready -> A then B, in order.
REQ-035 Capture wreg=1, rd=0, data=0x1234 -> o_wb_wreg=0, o_wb_rd=0; capture wreg=1, rd=7, data=0 -> o_wb_rd=7, o_wb_wreg=1.
REQ-036 mem2reg=1, dmem=0xDEADBEEF, data=0x5 -> o_wb_result=0xDEADBEEF; mem2reg=0 -> o_wb_result=0x5.
REQ-037 In TWO, assert i_flush with i_mem_valid=1 -> next cycle EMPTY, o_wb_valid=0, o_mem_ready=1, new entry dropped.
REQ-038 Drop i_resetn mid-stream -> outputs 0 and o_mem_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_wb_skid_pkg.sv
// Shared pipeline definitions for the MEM->WB skid buffer: occupancy state
// encoding and the bit layout of one stored entry record.
package mem_wb_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  // Entry record, MSB first: {mem2reg, wreg, rd[RD_W], data[XLEN], dmem[XLEN]}
  function automatic int ent_w(input int xlen, input int rd_w);
    return 2 * xlen + rd_w + 2;
  endfunction

  function automatic int ent_dmem_lsb();
    return 0;
  endfunction

  function automatic int ent_data_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int ent_rd_lsb(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int ent_wreg_bit(input int xlen, input int rd_w);
    return 2 * xlen + rd_w;
  endfunction

  function automatic int ent_mem2reg_bit(input int xlen, input int rd_w);
    return 2 * xlen + rd_w + 1;
  endfunction

endpackage

// File: rtl/mem_wb_skid.sv
// Two-entry MEM->WB skid buffer: head register drives the WB outputs, skid
// register absorbs one extra entry so o_mem_ready can come straight from a flop.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RD_W       = 5,
  parameter int FWD_RESULT = 1
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_flush,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  logic              i_mem_mem2reg,
  input  logic              i_mem_wreg,
  input  logic [RD_W-1:0]   i_mem_rd,
  input  logic [XLEN-1:0]   i_mem_data,
  input  logic [XLEN-1:0]   i_rd_dmem,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic              o_wb_mem2reg,
  output logic              o_wb_wreg,
  output logic [RD_W-1:0]   o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic [XLEN-1:0]   o_wb_dmem,
  output logic [XLEN-1:0]   o_wb_result,
  output skid_state_t       o_dbg_state
);

  localparam int EW       = ent_w(XLEN, RD_W);
  localparam int DMEM_LSB = ent_dmem_lsb();
  localparam int DATA_LSB = ent_data_lsb(XLEN);
  localparam int RD_LSB   = ent_rd_lsb(XLEN);
  localparam int WREG_BIT = ent_wreg_bit(XLEN, RD_W);
  localparam int M2R_BIT  = ent_mem2reg_bit(XLEN, RD_W);

  // Handshake: an entry moves on a rising edge only when valid and ready are
  // both high in that cycle; a flush at the same edge cancels both transfers.
  skid_state_t   state_q, state_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;

  logic          accept;
  logic          drain;
  logic          cap_wreg;
  logic [EW-1:0] cap;

  assign accept = i_mem_valid && ready_q;
  assign drain  = valid_q && i_wb_ready;

  // A write to x0 or a non-writing entry is normalised to wreg=0, rd=0.
  assign cap_wreg = i_mem_wreg && (i_mem_rd != {RD_W{1'b0}});
  assign cap = {i_mem_mem2reg, cap_wreg,
                (cap_wreg ? i_mem_rd : {RD_W{1'b0}}),
                i_mem_data, i_rd_dmem};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = cap;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          head_d = cap;
        end else if (accept) begin
          skid_d  = cap;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          head_d  = skid_q;
          skid_d  = '0;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (i_flush) begin
      state_d = ST_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_mem_ready  = ready_q;
  assign o_wb_valid   = valid_q;
  assign o_wb_mem2reg = head_q[M2R_BIT];
  assign o_wb_wreg    = head_q[WREG_BIT] && valid_q;
  assign o_wb_rd      = head_q[RD_LSB +: RD_W];
  assign o_wb_data    = head_q[DATA_LSB +: XLEN];
  assign o_wb_dmem    = head_q[DMEM_LSB +: XLEN];
  assign o_dbg_state  = state_q;

  generate
    if (FWD_RESULT != 0) begin : g_result
      assign o_wb_result = o_wb_mem2reg ? o_wb_dmem : o_wb_data;
    end else begin : g_no_result
      assign o_wb_result = '0;
    end
  endgenerate

endmodule
